// File: rtl/hash_validation_scheduler.sv
// hash_validation_scheduler
//   Shares one registered hash validator between NUM_CORES hash cores for a
//   mining job. Latches the job difficulty, grants cores round-robin, carries
//   each granted nonce/core alongside the validator pipeline, and reports the
//   first winning nonce and core.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   job_start/job_abort job control pulses (abort wins when both are high)
//   job_difficulty      compact difficulty, latched on job start
//   core_valid/hash/nonce, core_ready   per-core result handshake
//   val_hash/val_difficulty/val_success validator interface
//   busy, found, found_nonce, found_core, hashes_checked   job status
module hash_validation_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int VAL_LATENCY = 1,
  parameter int CORE_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_start,
  input  logic                     job_abort,
  input  logic [31:0]              job_difficulty,
  input  logic [NUM_CORES-1:0]     core_valid,
  input  logic [NUM_CORES*256-1:0] core_hash,
  input  logic [NUM_CORES*32-1:0]  core_nonce,
  output logic [NUM_CORES-1:0]     core_ready,
  output logic [255:0]             val_hash,
  output logic [31:0]              val_difficulty,
  input  logic                     val_success,
  output logic                     busy,
  output logic                     found,
  output logic [31:0]              found_nonce,
  output logic [CORE_W-1:0]        found_core,
  output logic [31:0]              hashes_checked
);

  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int DEPTH  = VAL_LATENCY + 1;
  localparam int TAG_W  = 1 + 32 + CORE_W;
  localparam int PIPE_W = DEPTH * TAG_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FOUND = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       nonce;
    logic [CORE_W-1:0] core;
  } tag_t;

  state_t            state_r, state_next_s;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [PIPE_W-1:0] tag_pipe_r;
  logic [PIPE_W-1:0] push_ext_s;
  tag_t              tag_out_s, push_tag_s;
  logic [255:0]      hash_arr_s  [NUM_CORES];
  logic [31:0]       nonce_arr_s [NUM_CORES];
  logic              win_s, grant_en_s, grant_found_s, hit_s, start_job_s;
  logic [IDX_W-1:0]  grant_idx_s, cand_s;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign hash_arr_s[g]  = core_hash[256*g +: 256];
    assign nonce_arr_s[g] = core_nonce[32*g +: 32];
  end

  // Oldest tag sits in the top slot; it lines up with val_success for its hash.
  assign tag_out_s   = tag_pipe_r[PIPE_W-1 -: TAG_W];
  assign win_s       = tag_out_s.valid & val_success;
  // A start in RUN is ignored, and abort overrides start.
  assign start_job_s = job_start & ~job_abort & (state_r != ST_RUN);
  // No grant in the cycle that leaves RUN, so nothing is lost in a flushed pipe.
  assign grant_en_s  = (state_r == ST_RUN) & ~job_abort & ~win_s;

  // Round-robin search starting one past the last granted core.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand_s        = IDX_W'((int'(rr_ptr_r) + k) % NUM_CORES);
      hit_s         = ~grant_found_s & core_valid[cand_s];
      grant_idx_s   = hit_s ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
    grant_found_s = grant_found_s & grant_en_s;
  end

  // One-hot grant and the tag that follows the granted hash.
  always_comb begin
    core_ready       = '0;
    push_tag_s.valid = grant_found_s;
    push_tag_s.nonce = nonce_arr_s[grant_idx_s];
    push_tag_s.core  = CORE_W'(grant_idx_s);
    push_ext_s       = '0;
    push_ext_s[TAG_W-1:0] = push_tag_s;
    if (grant_found_s) begin
      core_ready[grant_idx_s] = 1'b1;
    end else begin
      core_ready = '0;
    end
  end

  // Job sequencing: abort has priority over every other transition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (job_abort)      state_next_s = ST_IDLE;
        else if (job_start) state_next_s = ST_RUN;
        else                state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (job_abort)  state_next_s = ST_IDLE;
        else if (win_s) state_next_s = ST_FOUND;
        else            state_next_s = ST_RUN;
      end
      ST_FOUND: begin
        if (job_abort)      state_next_s = ST_IDLE;
        else if (job_start) state_next_s = ST_RUN;
        else                state_next_s = ST_FOUND;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      found   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == ST_RUN);
      found   <= (state_next_s == ST_FOUND);
    end
  end

  // Grant side: pointer and hash handed to the validator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= IDX_W'(NUM_CORES - 1);
      val_hash <= 256'd0;
    end else if (grant_found_s) begin
      rr_ptr_r <= grant_idx_s;
      val_hash <= hash_arr_s[grant_idx_s];
    end
  end

  // Tag pipe: shifts only while staying in RUN; leaving RUN or starting a job
  // empties it so late successes of discarded tags are never seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_pipe_r <= '0;
    end else if ((state_r == ST_RUN) && (state_next_s == ST_RUN)) begin
      tag_pipe_r <= (tag_pipe_r << TAG_W) | push_ext_s;
    end else begin
      tag_pipe_r <= '0;
    end
  end

  // Job results: difficulty latch, winner capture, saturating result count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_difficulty <= 32'd0;
      found_nonce    <= 32'd0;
      found_core     <= '0;
      hashes_checked <= 32'd0;
    end else if (start_job_s) begin
      val_difficulty <= job_difficulty;
      found_nonce    <= 32'd0;
      found_core     <= '0;
      hashes_checked <= 32'd0;
    end else begin
      if ((state_r == ST_RUN) && tag_out_s.valid &&
          (hashes_checked != 32'hFFFF_FFFF)) begin
        hashes_checked <= hashes_checked + 32'd1;
      end
      if ((state_r == ST_RUN) && (state_next_s == ST_FOUND)) begin
        found_nonce <= tag_out_s.nonce;
        found_core  <= tag_out_s.core;
      end
    end
  end

endmodule

// File: doc/hash_validation_scheduler.md
Name: hash_validation_scheduler

Overview:
- Shares one hash validator (registered output, compares the hash against the difficulty target) between NUM_CORES hash cores.
- Sits between the core array and the single validator instance.
- Sequences a mining job: latches difficulty, grants cores round-robin, tracks in-flight nonces through the validator pipeline, and reports the first winning nonce and core.

Parameters:
- NUM_CORES, 4, number of requesting hash cores (2..16).
- VAL_LATENCY, 1, cycles from val_hash/val_difficulty registered to val_success valid (validator register stage).
- CORE_W, 4, width of core index fields (must satisfy 2**CORE_W >= NUM_CORES).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- job_start  in  1  pulse: latch job_difficulty, begin a job.
- job_abort  in  1  pulse: terminate the current job and return to IDLE.
- job_difficulty  in  32  compact difficulty word, same encoding the validator consumes.
- core_valid  in  NUM_CORES  per-core result-available flag.
- core_hash  in  NUM_CORES*256  per-core hash; core i occupies bits [256*i+255:256*i].
- core_nonce  in  NUM_CORES*32  per-core nonce; core i occupies bits [32*i+31:32*i].
- core_ready  out  NUM_CORES  one-hot grant; result is consumed when core_valid[i] & core_ready[i].
- val_hash  out  256  registered hash presented to the validator.
- val_difficulty  out  32  latched job difficulty, stable for the whole job.
- val_success  in  1  validator result, VAL_LATENCY cycles after val_hash.
- busy  out  1  1 in RUN.
- found  out  1  1 in FOUND.
- found_nonce  out  32  winning nonce.
- found_core  out  CORE_W  index of the winning core.
- hashes_checked  out  32  count of validator results consumed in the current job.

Behaviour:
- Reset (async, rst=0) values:
  - state=IDLE; core_ready=0; busy=0; found=0.
  - found_nonce=0; found_core=0; hashes_checked=0.
  - val_hash=0; val_difficulty=0; RR pointer=NUM_CORES-1.
  - Tag pipe valid bits all 0.
- States: IDLE, RUN, FOUND.
  - IDLE -> RUN on job_start.
    - val_difficulty<=job_difficulty; hashes_checked<=0; found_nonce<=0; found_core<=0.
    - Tag pipe flushed.
  - RUN -> FOUND when the tag pipe output is valid and val_success=1.
    - Capture that tag's nonce and core into found_nonce/found_core.
  - RUN -> IDLE on job_abort; tag pipe flushed.
  - FOUND -> IDLE on job_abort.
  - FOUND -> RUN on job_start: same latch/clear as IDLE -> RUN.
  - job_abort and job_start in the same cycle: abort wins, next state IDLE.
  - job_start while in RUN: ignored.
- Arbitration (RUN only; core_ready=0 in IDLE and FOUND, and in the cycle RUN -> FOUND/IDLE):
  - Combinational round-robin: search starts at pointer+1 and wraps modulo NUM_CORES; the first core with core_valid=1 gets core_ready=1.
  - At most one grant per cycle.
  - On a grant: pointer<=granted index; val_hash<=core_hash slice; push tag {1, nonce, index} into the tag pipe.
  - No grant: push tag valid=0; val_hash holds its value.
- Tag pipe:
  - Depth VAL_LATENCY+1, so a tag exits aligned with val_success for the matching hash.
  - Total latency is grant cycle N -> val_hash at N+1 -> val_success sampled at N+1+VAL_LATENCY.
- hashes_checked:
  - Increments by 1 for each valid tag exiting the pipe while in RUN, including the winning one.
  - Saturates at 32'hFFFFFFFF.
  - Holds in FOUND and IDLE.
- First winner only:
  - Tags still in flight after a success are discarded.
  - Their val_success is ignored and they are not counted.
- val_success with no valid tag: ignored.
- Outputs found_nonce, found_core and hashes_checked hold until the next job_start or reset.

Test Plan:
- Reset mid-RUN with 2 tags in flight -> next cycle all outputs at reset values; val_success=1 arriving afterwards produces no found.
- NUM_CORES=4, all core_valid=1 continuously, validator stub never succeeds -> grant order 0,1,2,3,0,...; after 100 grant cycles hashes_checked = 100 - (VAL_LATENCY+1) = 98.
- Only core 2 valid, nonce 32'h0000BEEF; stub returns success on that hash -> found=1 exactly at grant+1+VAL_LATENCY+1; found_nonce=32'h0000BEEF; found_core=2; busy=0; core_ready=0 thereafter.
- Success on the first of two back-to-back grants (cores 1 then 3) -> found_core=1; core 3's result is not counted and its later success does not change found_nonce.
- job_abort and job_start asserted together in FOUND -> state IDLE, found=0, val_difficulty unchanged; a subsequent job_start with difficulty 32'h1D00FFFF sets val_difficulty=32'h1D00FFFF and hashes_checked=0.
- hashes_checked preloaded near saturation via force to 32'hFFFFFFFE, then 3 results returned -> reads 32'hFFFFFFFF.
